// File: rtl/tis_stack_if.sv
// tis_stack_if: neighbour-link bundle between a tis_stack_node and its neighbours.
//   in_data  [NPORTS][WIDTH] push word per port
//   in_valid [NPORTS]        push request per port, held until in_ready
//   in_ready [NPORTS]        push accepted this cycle (combinational grant)
//   rd_req   [NPORTS]        pop request per port, held until rd_valid seen
//   rd_valid [NPORTS]        one-cycle pulse marking rd_data for that port
//   rd_data  [WIDTH]         popped word, shared by all ports
// master = neighbours side, slave = stack node side.
interface tis_stack_if #(
   parameter int WIDTH  = 11,
   parameter int NPORTS = 4
);
   logic [NPORTS-1:0][WIDTH-1:0] in_data;
   logic [NPORTS-1:0]            in_valid;
   logic [NPORTS-1:0]            in_ready;
   logic [NPORTS-1:0]            rd_req;
   logic [NPORTS-1:0]            rd_valid;
   logic [WIDTH-1:0]             rd_data;

   modport master (
      output in_data, in_valid, rd_req,
      input  in_ready, rd_valid, rd_data
   );

   modport slave (
      input  in_data, in_valid, rd_req,
      output in_ready, rd_valid, rd_data
   );
endinterface

// File: rtl/tis_stack_node.sv
// tis_stack_node: LIFO stack memory node with NPORTS blocking neighbour links.
// A neighbour write pushes one word, a neighbour read pops one word. At most
// one push or pop happens per cycle; when both kinds are requesting, the kind
// not granted last time wins, and within a kind the lowest port index wins.
// Ports:
//   clk   - clock, all state on rising edge
//   rst   - synchronous active-high reset
//   bus   - tis_stack_if.slave neighbour links (push/pop handshakes, rd_data)
//   count - current occupancy
//   full  - count == DEPTH
//   empty - count == 0
module tis_stack_node #(
   parameter int WIDTH  = 11,
   parameter int DEPTH  = 15,
   parameter int NPORTS = 4,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   tis_stack_if.slave      bus,
   output logic [CW-1:0]   count,
   output logic            full,
   output logic            empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

   typedef enum logic {OP_PUSH, OP_POP} op_e;

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [CW-1:0]     count_q, count_d;
   logic [NPORTS-1:0] rd_valid_q, rd_valid_d;
   logic [WIDTH-1:0]  rd_data_q, rd_data_d;
   op_e               last_type_q, last_type_d;

   logic [NPORTS-1:0] p_cand, q_cand, in_ready;
   logic [IW-1:0]     push_idx, pop_idx;
   logic              do_push, do_pop;
   logic [AW-1:0]     wr_addr, rd_addr;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

   assign bus.in_ready = in_ready;
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_data_q;

   // NOTE: every signal written here gets a default first so no path can leave
   // it unassigned and infer a latch.
   always_comb begin
      p_cand      = bus.in_valid & {NPORTS{!full}};
      // A port that is seeing its rd_valid this cycle still has rd_req high;
      // masking it prevents popping a second word for the same request.
      q_cand      = bus.rd_req & ~rd_valid_q & {NPORTS{!empty}};
      push_idx    = '0;
      pop_idx     = '0;
      // Scan downwards so the lowest requesting index is the one left standing.
      for (int i = NPORTS - 1; i >= 0; i--) begin
         if (p_cand[i]) push_idx = IW'(i);
         if (q_cand[i]) pop_idx  = IW'(i);
      end
      // When both kinds request, alternate against the last granted kind.
      do_push     = !rst && (|p_cand) && (!(|q_cand) || (last_type_q == OP_POP));
      do_pop      = !rst && (|q_cand) && !do_push;
      wr_addr     = AW'(count_q);
      rd_addr     = AW'(count_q - CW'(1));

      in_ready    = '0;
      rd_valid_d  = '0;
      rd_data_d   = rd_data_q;
      count_d     = count_q;
      last_type_d = last_type_q;

      if (do_push) begin
         in_ready[push_idx] = 1'b1;
         count_d            = count_q + CW'(1);
         last_type_d        = OP_PUSH;
      end else if (do_pop) begin
         rd_valid_d[pop_idx] = 1'b1;
         rd_data_d           = mem[rd_addr];
         count_d             = count_q - CW'(1);
         last_type_d         = OP_POP;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q     <= '0;
         rd_valid_q  <= '0;
         rd_data_q   <= '0;
         last_type_q <= OP_POP;
      end else begin
         count_q     <= count_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
         last_type_q <= last_type_d;
      end
   end

   // NOTE: the word array has no reset; count alone defines which entries are
   // live, so stale contents are never observable.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_addr] <= bus.in_data[push_idx];
   end
endmodule

// File: doc/tis_stack_node.md
# tis_stack_node

Parametrised TIS stack-memory node for the tiscomp FPGA fabric. It sits in the node grid beside `core` instances, and its NPORTS directional neighbour links use the same blocking semantics as core ports. Any neighbour write pushes one word. Any neighbour read pops one word (LIFO). It generalises the fixed four-port, 11-bit node link to configurable width, depth and port count, and adds occupancy reporting plus fair push/pop arbitration.

## Interface
Parameters:
- WIDTH, 11, data word width (two's complement, stored verbatim)
- DEPTH, 15, stack capacity in words (≥2)
- NPORTS, 4, neighbour link count (index 0=L, 1=R, 2=U, 3=D when 4)

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  NPORTS×WIDTH  push word per port
- in_valid  input  NPORTS  push request per port, held until accepted
- in_ready  output  NPORTS  push accepted this cycle (combinational grant)
- rd_req  input  NPORTS  pop request per port, held until rd_valid seen
- rd_valid  output  NPORTS  one-cycle pulse, popped word on rd_data for that port
- rd_data  output  WIDTH  popped word (shared, qualified by rd_valid)
- count  output  $clog2(DEPTH+1)  current occupancy
- full  output  1  count==DEPTH
- empty  output  1  count==0

## Operation
- Storage: DEPTH×WIDTH register array, not reset; count is the stack pointer; top = mem[count-1].
- At most one operation (push or pop) per cycle.
- Push candidates: P = in_valid & {NPORTS{!full}}.
- Pop candidates: Q = rd_req & ~rd_valid & {NPORTS{!empty}}. Masking with rd_valid prevents a double pop while the requester drops rd_req.
- Type selection: if P and Q are both non-zero, grant the type ≠ last_type. Otherwise grant whichever is non-zero. With neither, idle.
- Port selection within a type: lowest index wins.
- Push grant on port i: in_ready[i]=1 that cycle; at edge mem[count]<=in_data[i], count+1, last_type<=PUSH.
- Pop grant on port i: at edge rd_data<=mem[count-1], rd_valid<=one-hot(i), count-1, last_type<=POP.
- A port may hold push and pop requests at once; they are independent candidates.
- No value arithmetic or saturation; words round-trip bit-exact.
- full/empty are combinational from count.

## Timing
- Reset: count=0, rd_valid=0, rd_data=0, last_type=POP (push preferred first); in_ready=0 while rst=1; requests present during rst are ignored.
- Push latency: accepted in the request cycle when granted; count and full update next cycle.
- Pop latency: grant cycle t, rd_valid/rd_data at t+1 for exactly one cycle; rd_data holds until the next pop.
- Full: pushes block (in_ready=0); pops proceed. Empty: pops block; pushes proceed.
- Push and pop never collide in one cycle, so full→pop and empty→push are ordinary single ops.
- Reset mid-operation: a pending rd_valid is cleared, stack contents are discarded (count=0), and no grant is issued in the rst cycle.
- Starvation bound: with both types requesting, each type is granted at least every other cycle.

## Test plan
- Reset, then in_valid[0]=1, in_data=5 → in_ready[0]=1 same cycle; count=1, empty=0 next cycle.
- Push 1,2,3 on port 0, then hold rd_req[2] → rd_valid=4'b0100 three times with rd_data 3,2,1 (one cycle after each grant); count=0, empty=1.
- Push 15 words (0..14) → full=1; a 16th push of 99 on port 1 holds in_ready[1]=0. Pop on port 3 → rd_data=14, and 99 is accepted the following cycle; count back to 15.
- Empty, rd_req[1]=1 for 3 cycles → no rd_valid. Push 11'h7FF on port 3 → next cycle pop granted, rd_data=11'h7FF (−1 preserved).
- count=2, last_type=POP, with in_valid[1], in_valid[3], rd_req[0] all high → cycle order: push port 1, pop port 0, push port 3. Each in_ready or rd_valid is one-hot.
- Assert rst while count=5 and a pop grant is pending → next cycle rd_valid=0, count=0, rd_data=0, and no in_ready is issued during rst.
